// File: rtl/mmio_periph_pkg.sv
// Shared definitions for the MMIO UART/LED peripheral: register map, STATUS layout,
// transmitter states and small helpers.
package mmio_periph_pkg;

    localparam int unsigned REG_UART   = 0;
    localparam int unsigned REG_LED    = 1;

    localparam int unsigned ST_BUSY    = 32;
    localparam int unsigned ST_FULL    = 33;
    localparam int unsigned ST_LVL_LSB = 48;
    localparam int unsigned ST_OVF     = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic logic [63:0] byte_mask_expand(input logic [7:0] mask);
        logic [63:0] m;
        m = 64'd0;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{mask[b]}};
        end
        return m;
    endfunction

    // A zero divider would stall the line forever, so it is promoted to one clock.
    function automatic logic [15:0] bit_period(input logic [15:0] ckdiv);
        return (ckdiv == 16'd0) ? 16'd1 : ckdiv;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART transmitter.
module mmio_tx_fifo
    import mmio_periph_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] cnt_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Accept a push when there is room, including the slot freed by a same-cycle pop.
    always_comb begin
        pop_ok_s  = pop && (cnt_r != LW'(0));
        push_ok_s = push && ((cnt_r != LW'(DEPTH)) || pop_ok_s);
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            cnt_r    <= LW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + LW'(1);
                2'b01:   cnt_r <= cnt_r - LW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (cnt_r == LW'(DEPTH));
    assign empty = (cnt_r == LW'(0));
    assign level = cnt_r;

endmodule

// File: rtl/mmio_uart_led_periph.sv
// MMIO slave with readable CKDIV/STATUS and LED registers and an 8N1 UART transmitter
// fed from a byte FIFO.
module mmio_uart_led_periph
    import mmio_periph_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned CKDIV_RST  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [63:0]       W0_data,
    input  logic [7:0]        W0_mask,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [63:0]       R0_data,
    output logic              uart_tx,
    output logic [LED_W-1:0]  leds
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ckdiv_r;
    logic [LED_W-1:0] led_r;
    logic             ovf_r;
    logic [63:0]      rdata_r;
    tx_state_e        state_r;
    logic             tx_r;
    logic [15:0]      cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_dout_s;
    logic [LVL_W-1:0] fifo_level_s;

    logic             wr_uart_s;
    logic             wr_led_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             busy_s;
    logic             bit_end_s;
    logic [15:0]      period_s;
    logic [63:0]      wmask_s;
    logic [63:0]      led_ext_s;
    logic [63:0]      led_new_s;
    logic [31:0]      ckdiv_new_s;
    logic [63:0]      status_s;
    logic [63:0]      rd_mux_s;
    logic             unused_s;

    // Write decode and byte-merged next values for the writable registers.
    always_comb begin
        wr_uart_s   = W0_en && (W0_addr == ADDR_W'(REG_UART));
        wr_led_s    = W0_en && (W0_addr == ADDR_W'(REG_LED));
        push_s      = wr_uart_s && W0_mask[4];
        ovf_clr_s   = wr_uart_s && W0_mask[7] && W0_data[63];
        wmask_s     = byte_mask_expand(W0_mask);
        ckdiv_new_s = (ckdiv_r & ~wmask_s[31:0]) | (W0_data[31:0] & wmask_s[31:0]);
        led_ext_s   = 64'd0;
        led_ext_s[LED_W-1:0] = led_r;
        led_new_s   = (led_ext_s & ~wmask_s) | (W0_data & wmask_s);
    end

    // Transmitter handshake: pop from IDLE, or at the end of STOP so frames run gap-free.
    always_comb begin
        period_s  = bit_period(ckdiv_r[15:0]);
        bit_end_s = (cnt_r == 16'd0);
        pop_s     = !fifo_empty_s &&
                    ((state_r == IDLE) || ((state_r == STOP) && bit_end_s));
        busy_s    = (state_r != IDLE) || !fifo_empty_s;
        ovf_set_s = push_s && fifo_full_s && !pop_s;
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        status_s = 64'd0;
        status_s[31:0]                = ckdiv_r;
        status_s[ST_BUSY]             = busy_s;
        status_s[ST_FULL]             = fifo_full_s;
        status_s[ST_LVL_LSB +: 8]     = 8'(fifo_level_s);
        status_s[ST_OVF]              = ovf_r;
        if (R0_addr == ADDR_W'(REG_UART)) begin
            rd_mux_s = status_s;
        end else if (R0_addr == ADDR_W'(REG_LED)) begin
            rd_mux_s = led_ext_s;
        end else begin
            rd_mux_s = 64'hFFFF_FFFF_FFFF_FFFF;
        end
    end

    assign unused_s = ^{W0_data[62:40], led_new_s};

    // Software-visible registers and the read-data holding register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ckdiv_r <= 32'(CKDIV_RST);
            led_r   <= {LED_W{1'b0}};
            ovf_r   <= 1'b0;
            rdata_r <= 64'd0;
        end else begin
            if (wr_uart_s) begin
                ckdiv_r <= ckdiv_new_s;
            end
            if (wr_led_s) begin
                led_r <= led_new_s[LED_W-1:0];
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
            if (R0_en) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    // 8N1 transmit FSM; every bit reloads its length from the live divider.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            tx_r      <= 1'b1;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shift_r <= fifo_dout_s;
                        cnt_r   <= period_s - 16'd1;
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        cnt_r     <= period_s - 16'd1;
                        tx_r      <= shift_r[0];
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= period_s - 16'd1;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        if (pop_s) begin
                            shift_r <= fifo_dout_s;
                            cnt_r   <= period_s - 16'd1;
                            tx_r    <= 1'b0;
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .din     (W0_data[39:32]),
        .dout    (fifo_dout_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    assign R0_data = rdata_r;
    assign uart_tx = tx_r;
    assign leds    = led_r;

endmodule

// File: tb/tb_mmio_uart_led_periph.sv
// Self-checking bench: a queue/frame-level model of the peripheral checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mmio_uart_led_periph;

    localparam int DEPTH = 8;
    localparam logic [63:0] LED_MASK = 64'h0000_0000_0000_00FF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  W0_addr = 9'd0;
    logic        W0_en = 1'b0;
    logic [63:0] W0_data = 64'd0;
    logic [7:0]  W0_mask = 8'd0;
    logic [8:0]  R0_addr = 9'd0;
    logic        R0_en = 1'b0;
    logic [63:0] R0_data;
    logic        uart_tx;
    logic [7:0]  leds;

    int total = 0;
    int bad = 0;

    mmio_uart_led_periph #(
        .ADDR_W(9), .FIFO_DEPTH(DEPTH), .LED_W(8), .CKDIV_RST(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
        .uart_tx(uart_tx), .leds(leds)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ck = 32'd16;
    logic [63:0] m_led = 64'd0;
    bit          m_ovf = 1'b0;
    logic [7:0]  m_q[$];
    logic [63:0] m_rd = 64'd0;
    bit          m_act = 1'b0;
    int          m_bit = 0;
    int          m_left = 0;
    logic [9:0]  m_frame = 10'h3FF;
    bit          m_ovf_set;

    function automatic int period(input logic [31:0] ck);
        return (ck[15:0] == 16'd0) ? 1 : int'(ck[15:0]);
    endfunction

    function automatic logic [63:0] mread(input logic [8:0] a);
        logic [63:0] v;
        if (a == 9'd0) begin
            v = 64'd0;
            v[63]    = m_ovf;
            v[55:48] = 8'(m_q.size());
            v[33]    = (m_q.size() == DEPTH);
            v[32]    = m_act || (m_q.size() != 0);
            v[31:0]  = m_ck;
        end else if (a == 9'd1) begin
            v = m_led & LED_MASK;
        end else begin
            v = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        return v;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ck = 32'd16; m_led = 64'd0; m_ovf = 1'b0; m_q.delete();
            m_rd = 64'd0; m_act = 1'b0; m_bit = 0; m_left = 0; m_frame = 10'h3FF;
        end else begin
            if (R0_en) m_rd = mread(R0_addr);
            if (m_act) begin
                m_left--;
                if (m_left == 0) begin
                    m_bit++;
                    if (m_bit == 10) m_act = 1'b0;
                    else m_left = period(m_ck);
                end
            end
            if (!m_act && m_q.size() > 0) begin
                m_frame = {1'b1, m_q.pop_front(), 1'b0};
                m_bit = 0; m_left = period(m_ck); m_act = 1'b1;
            end
            m_ovf_set = 1'b0;
            if (W0_en && W0_addr == 9'd0) begin
                if (W0_mask[4]) begin
                    if (m_q.size() < DEPTH) m_q.push_back(W0_data[39:32]);
                    else m_ovf_set = 1'b1;
                end
                if (W0_mask[7] && W0_data[63]) m_ovf = 1'b0;
                for (int b = 0; b < 4; b++)
                    if (W0_mask[b]) m_ck[b*8 +: 8] = W0_data[b*8 +: 8];
            end
            if (m_ovf_set) m_ovf = 1'b1;
            if (W0_en && W0_addr == 9'd1) begin
                for (int b = 0; b < 8; b++)
                    if (W0_mask[b]) m_led[b*8 +: 8] = W0_data[b*8 +: 8];
            end
        end
    end

    // Per-cycle compare against the model.
    always @(posedge clock) begin
        #1;
        check("tx_line", {63'd0, uart_tx}, {63'd0, (m_act ? m_frame[m_bit] : 1'b1)});
        check("leds", {56'd0, leds}, m_led & LED_MASK);
        check("rdata", R0_data, m_rd);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
        @(negedge clock);
        W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m; R0_en = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a);
        @(negedge clock);
        R0_en = 1'b1; R0_addr = a; W0_en = 1'b0;
    endtask

    task automatic idle();
        @(negedge clock);
        W0_en = 1'b0; R0_en = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [8:0] a, input logic [63:0] exp);
        rd(a);
        idle();
        check(name, R0_data, exp);
    endtask

    task automatic wait_fall(input string name);
        int k;
        k = 0;
        while (uart_tx !== 1'b0 && k < 12) begin
            @(negedge clock);
            k++;
        end
        check(name, {63'd0, uart_tx}, 64'd0);
    endtask

    initial begin
        logic [9:0] pat;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Reset state
        check("reset_tx", {63'd0, uart_tx}, 64'd1);
        rd_check("reset_status", 9'h000, 64'h0000_0000_0000_0010);
        rd_check("reset_leds", 9'h001, 64'd0);

        // 0x55 frame at CKDIV=4
        wr(9'h000, 64'd4, 8'h0F);
        wr(9'h000, 64'h0000_0055_0000_0000, 8'h10);
        idle();
        wait_fall("frame55_start");
        pat = 10'h2AA;
        for (int c = 0; c < 40; c++) begin
            check("frame55_bit", {63'd0, uart_tx}, {63'd0, pat[c/4]});
            @(negedge clock);
        end
        check("frame55_end", {63'd0, uart_tx}, 64'd1);
        rd_check("frame55_idle_status", 9'h000, 64'h0000_0000_0000_0004);

        // Overflow at CKDIV=100
        wr(9'h000, 64'd100, 8'h0F);
        for (int i = 0; i < 10; i++)
            wr(9'h000, {24'd0, 8'(8'h10 + i), 32'd0}, 8'h10);
        idle();
        rd_check("ovf_status", 9'h000, 64'h8008_0003_0000_0064);
        wr(9'h000, 64'h8000_0000_0000_0000, 8'h80);
        idle();
        rd_check("ovf_cleared", 9'h000, 64'h0008_0003_0000_0064);

        // LEDs, same-cycle read/write
        wr(9'h001, 64'h0000_0000_0000_00A5, 8'h01);
        idle();
        check("leds_a5", {56'd0, leds}, 64'h0000_0000_0000_00A5);
        rd(9'h001);
        @(negedge clock);
        W0_en = 1'b1; W0_addr = 9'h001; W0_data = 64'h3C; W0_mask = 8'h01;
        R0_en = 1'b1; R0_addr = 9'h001;
        check("led_read_latency", R0_data, 64'h0000_0000_0000_00A5);
        idle();
        check("led_read_prewrite", R0_data, 64'h0000_0000_0000_00A5);
        rd_check("led_read_new", 9'h001, 64'h0000_0000_0000_003C);

        // Unmapped addresses
        rd_check("unmapped_1ff", 9'h1FF, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_check("unmapped_002", 9'h002, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(9'h002, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        idle();
        rd_check("unmapped_wr_led", 9'h001, 64'h0000_0000_0000_003C);
        rd_check("unmapped_wr_uart", 9'h000, 64'h0008_0003_0000_0064);

        // Reset in the middle of DATA (byte 0x10, data bit 1 is low)
        repeat (200) @(negedge clock);
        check("pre_reset_tx_low", {63'd0, uart_tx}, 64'd0);
        reset_n = 1'b0;
        #1;
        check("reset_tx_immediate", {63'd0, uart_tx}, 64'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        rd_check("post_reset_status", 9'h000, 64'h0000_0000_0000_0010);

        // Transmission after reset
        wr(9'h000, 64'h0000_00C3_0000_0000, 8'h10);
        idle();
        wait_fall("post_reset_start");
        repeat (170) @(negedge clock);
        rd_check("post_reset_done", 9'h000, 64'h0000_0000_0000_0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
